lfsr_bit_interleaver: RTL and testbench

Parametrised pseudo-random bit-swap interleaver/deinterleaver for the turbo encoder datapath. Each accepted WIDTH-bit word is permuted by WIDTH sequential conditional adjacent-bit swaps. The swaps are keyed by an internal Fibonacci LFSR that advances once per accepted word, so two instances with the same SEED/TAPS stay in key lockstep. A mode input selects forward (interleave) or inverse (deinterleave) swap order; valid/ready handshakes are provided on both sides.

---
 rtl/lfsr_bit_interleaver.sv | 150 +++++++++++++++
 tb/tb_lfsr_bit_interleaver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bit_interleaver.sv
// LFSR-keyed bit-swap interleaver/deinterleaver.
// Each accepted word is permuted by WIDTH conditional adjacent-bit swaps.
// Bit i of the key enables the swap of bit i with bit (i-1) mod WIDTH.
// Interleave walks i from WIDTH-1 down to 0. Deinterleave walks i from 0 up,
// so the same key undoes the permutation.
// The key comes from a Fibonacci LFSR that advances once per accepted word.
`timescale 1ns/1ps

module lfsr_bit_interleaver #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'hAA
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reseed,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_key
);

   // The step counter runs 0..WIDTH. The final count is the hand-off cycle
   // that moves the result into the output registers.
   localparam int SW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SWAP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    step_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] key_q;
   logic             mode_q;
   logic [WIDTH-1:0] out_data_q;
   logic [WIDTH-1:0] out_key_q;

   logic             accept;
   logic             last_step;
   logic [SW-1:0]    idx;
   logic [WIDTH-1:0] sel_i;
   logic [WIDTH-1:0] sel_p;
   logic             bit_i;
   logic             bit_p;
   logic             key_bit;
   logic             do_swap;
   logic [WIDTH-1:0] swapped;

   assign accept    = (state_q == IDLE) && in_valid;
   assign last_step = (step_q == SW'(WIDTH));
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign out_key   = out_key_q;

   // Fibonacci feedback: parity of the tapped bits enters at the MSB.
   assign lfsr_next = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};

   // Swap position for this step and its circular lower neighbour.
   // Both positions are one-hot masks, so no variable bit indexing is needed.
   // sel_p is sel_i rotated right by one, which wraps bit 0 onto bit WIDTH-1.
   always_comb begin
      idx = mode_q ? step_q : (SW'(WIDTH - 1) - step_q);
      for (int unsigned b = 0; b < WIDTH; b++) begin
         sel_i[b] = (SW'(b) == idx);
      end
   end

   assign sel_p   = {sel_i[0], sel_i[WIDTH-1:1]};
   assign bit_i   = |(work_q & sel_i);
   assign bit_p   = |(work_q & sel_p);
   assign key_bit = |(key_q & sel_i);
   assign do_swap = (state_q == SWAP) && !last_step && key_bit;

   // Conditional exchange of the two selected bits of the work register.
   always_comb begin
      swapped = work_q;
      if (do_swap) begin
         swapped = (work_q & ~(sel_i | sel_p))
                 | ({WIDTH{bit_p}} & sel_i)
                 | ({WIDTH{bit_i}} & sel_p);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for IDLE -> SWAP -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = SWAP;
         SWAP:    if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Key generator. Reseed wins over an advance in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else if (reseed) begin
         lfsr_q <= SEED;
      end else if (accept) begin
         lfsr_q <= lfsr_next;
      end
   end

   // Datapath: capture on accept, one swap per SWAP cycle, then publish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q     <= '0;
         work_q     <= '0;
         key_q      <= '0;
         mode_q     <= 1'b0;
         out_data_q <= '0;
         out_key_q  <= '0;
      end else if (accept) begin
         step_q <= '0;
         work_q <= in_data;
         key_q  <= lfsr_q;
         mode_q <= mode;
      end else if (state_q == SWAP) begin
         if (last_step) begin
            out_data_q <= work_q;
            out_key_q  <= key_q;
         end else begin
            work_q <= swapped;
            step_q <= step_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_bit_interleaver.sv
// Directed testbench for lfsr_bit_interleaver (WIDTH=8, TAPS=8'h1D, SEED=8'hAA).
// A second instance in deinterleave mode is chained behind the first one for
// the round-trip run.
`timescale 1ns/1ps

module tb_lfsr_bit_interleaver;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       reseed    = 1'b0;
   logic       mode      = 1'b0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b1;
   logic       chain_en  = 1'b0;
   logic [7:0] in_data   = 8'h00;

   logic       in_ready, out_valid;
   logic [7:0] out_data, out_key;
   logic       dut_out_ready;
   logic       d_in_valid, d_in_ready, d_out_valid;
   logic [7:0] d_out_data, d_out_key;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign dut_out_ready = chain_en ? d_in_ready : out_ready;
   assign d_in_valid    = chain_en & out_valid;

   lfsr_bit_interleaver #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hAA)) dut (
      .clk(clk), .rst_n(rst_n), .reseed(reseed), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(dut_out_ready),
      .out_data(out_data), .out_key(out_key)
   );

   lfsr_bit_interleaver #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hAA)) u_deint (
      .clk(clk), .rst_n(rst_n), .reseed(reseed), .mode(1'b1),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(out_data),
      .out_valid(d_out_valid), .out_ready(1'b1),
      .out_data(d_out_data), .out_key(d_out_key)
   );

   initial begin
      #3000000;
      $display("FAIL watchdog expired, simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_reseed();
      @(negedge clk);
      reseed = 1'b1;
      @(negedge clk);
      reseed = 1'b0;
   endtask

   // Present one word. Returns at the negedge after the accept edge.
   // in_data and mode are scrambled afterwards, because they must be ignored.
   task automatic send_word(input logic [7:0] d, input logic m, input logic rs);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout in_ready=%b required 1", in_ready);
      end
      in_data  = d;
      mode     = m;
      in_valid = 1'b1;
      reseed   = rs;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      reseed   = 1'b0;
      in_data  = 8'($urandom);
      mode     = ~m;
   endtask

   // Count edges from the accept edge until out_valid is seen; bounded at 40.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_word(input logic [7:0] d, input logic m, input logic rs,
                           output logic [7:0] od, output logic [7:0] ok,
                           output int lat);
      send_word(d, m, rs);
      wait_out(lat);
      od = out_data;
      ok = out_key;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data got %h want 00", out_data); end
      tests++; if (out_key !== 8'h00) begin fails++; $display("FAIL rst_out_key got %h want 00", out_key); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_interleave();
      logic [7:0] od, ok;
      int lat;
      run_word(8'h01, 1'b0, 1'b0, od, ok, lat);
      tests++; if (lat !== 9) begin fails++; $display("FAIL il_latency got %0d want 9", lat); end
      tests++; if (od !== 8'h02) begin fails++; $display("FAIL il1_data got %h want 02", od); end
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL il1_key got %h want aa", ok); end
      run_word(8'h01, 1'b0, 1'b0, od, ok, lat);
      tests++; if (od !== 8'h80) begin fails++; $display("FAIL il2_data got %h want 80", od); end
      tests++; if (ok !== 8'hD5) begin fails++; $display("FAIL il2_key got %h want d5", ok); end
      pulse_reseed();
      run_word(8'h80, 1'b0, 1'b0, od, ok, lat);
      tests++; if (od !== 8'h40) begin fails++; $display("FAIL il3_data got %h want 40", od); end
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL il3_key got %h want aa", ok); end
   endtask

   task automatic test_deinterleave();
      logic [7:0] od, ok;
      int lat;
      pulse_reseed();
      run_word(8'h02, 1'b1, 1'b0, od, ok, lat);
      tests++; if (lat !== 9) begin fails++; $display("FAIL dl_latency got %0d want 9", lat); end
      tests++; if (od !== 8'h01) begin fails++; $display("FAIL dl1_data got %h want 01", od); end
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL dl1_key got %h want aa", ok); end
      // Key D5 has bit 0 set, which exercises the wrap swap of bit 0 with bit 7.
      run_word(8'h80, 1'b1, 1'b0, od, ok, lat);
      tests++; if (od !== 8'h01) begin fails++; $display("FAIL dl2_data got %h want 01", od); end
      tests++; if (ok !== 8'hD5) begin fails++; $display("FAIL dl2_key got %h want d5", ok); end
   endtask

   task automatic test_backpressure();
      logic [7:0] od, ok;
      int lat;
      apply_reset();
      out_ready = 1'b0;
      run_word(8'h01, 1'b0, 1'b0, od, ok, lat);
      tests++; if (lat !== 9) begin fails++; $display("FAIL bp_latency got %0d want 9", lat); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
         tests++; if (out_data !== 8'h02) begin fails++; $display("FAIL bp_data[%0d] got %h want 02", i, out_data); end
         tests++; if (out_key !== 8'hAA) begin fails++; $display("FAIL bp_key[%0d] got %h want aa", i, out_key); end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      run_word(8'h01, 1'b0, 1'b0, od, ok, lat);
      tests++; if (od !== 8'h80) begin fails++; $display("FAIL bp_next_data got %h want 80", od); end
      tests++; if (ok !== 8'hD5) begin fails++; $display("FAIL bp_next_key got %h want d5", ok); end
   endtask

   task automatic test_reseed_accept();
      logic [7:0] od, ok;
      int lat;
      apply_reset();
      run_word(8'h01, 1'b0, 1'b0, od, ok, lat);
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL ra_first_key got %h want aa", ok); end
      run_word(8'h01, 1'b0, 1'b1, od, ok, lat);
      tests++; if (ok !== 8'hD5) begin fails++; $display("FAIL ra_same_cycle_key got %h want d5", ok); end
      tests++; if (od !== 8'h80) begin fails++; $display("FAIL ra_same_cycle_data got %h want 80", od); end
      run_word(8'h80, 1'b0, 1'b0, od, ok, lat);
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL ra_next_key got %h want aa", ok); end
      tests++; if (od !== 8'h40) begin fails++; $display("FAIL ra_next_data got %h want 40", od); end
   endtask

   task automatic test_reseed_swap();
      logic [7:0] od, ok;
      int lat;
      // The LFSR holds D5 here: the last accept used key AA.
      send_word(8'h01, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      reseed = 1'b1;
      @(negedge clk);
      reseed = 1'b0;
      wait_out(lat);
      tests++; if (out_data !== 8'h80) begin fails++; $display("FAIL rs_inflight_data got %h want 80", out_data); end
      tests++; if (out_key !== 8'hD5) begin fails++; $display("FAIL rs_inflight_key got %h want d5", out_key); end
      run_word(8'h80, 1'b0, 1'b0, od, ok, lat);
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL rs_next_key got %h want aa", ok); end
      tests++; if (od !== 8'h40) begin fails++; $display("FAIL rs_next_data got %h want 40", od); end
   endtask

   task automatic test_reset_mid_swap();
      logic [7:0] od, ok;
      int lat;
      // The outputs still hold 40/AA from the previous word.
      send_word(8'h01, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got %b want 0", out_valid); end
      tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rm_data got %h want 00", out_data); end
      tests++; if (out_key !== 8'h00) begin fails++; $display("FAIL rm_key got %h want 00", out_key); end
      @(negedge clk);
      rst_n = 1'b1;
      run_word(8'h80, 1'b0, 1'b0, od, ok, lat);
      tests++; if (lat !== 9) begin fails++; $display("FAIL rm_latency got %0d want 9", lat); end
      tests++; if (ok !== 8'hAA) begin fails++; $display("FAIL rm_key_after got %h want aa", ok); end
      tests++; if (od !== 8'h40) begin fails++; $display("FAIL rm_data_after got %h want 40", od); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      int got;
      int cyc;
      apply_reset();
      chain_en = 1'b1;
      got = 0;
      cyc = 0;
      fork
         begin
            for (int i = 0; i < 256; i++) begin
               logic [7:0] d;
               d = 8'($urandom);
               q.push_back(d);
               send_word(d, 1'b0, 1'b0);
            end
         end
         begin
            while (got < 256 && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               if (d_out_valid) begin
                  logic [7:0] exp_d;
                  exp_d = q.pop_front();
                  tests++;
                  if (d_out_data !== exp_d) begin
                     fails++;
                     $display("FAIL rt_word[%0d] got %h want %h key %h", got, d_out_data, exp_d, d_out_key);
                  end
                  got++;
               end
            end
         end
      join
      tests++; if (got !== 256) begin fails++; $display("FAIL rt_count got %0d want 256", got); end
      chain_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_interleave();
      test_deinterleave();
      test_backpressure();
      test_reseed_accept();
      test_reseed_swap();
      test_reset_mid_swap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
